// File: rtl/wb_cpu_master.sv
// wb_cpu_master: Wishbone classic single-cycle master between the 6507 CPU
// core and the wb_tia register slave. Each CPU request becomes exactly one
// STB/ACK transaction. The CPU is held while the slave stalls (WSYNC).
// Optional build macro WB_TIMEOUT_EN aborts a transaction that gets no ack
// within TIMEOUT_CYCLES bus cycles. An aborted transaction pulses cpu_err_o.
module wb_cpu_master #(
  parameter int WB_DATA_WIDTH  = 8,
  parameter int WB_ADDR_WIDTH  = 7,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cpu_req_i,
  input  logic                     cpu_we_i,
  input  logic [15:0]              cpu_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] cpu_wdata_i,
  output logic [WB_DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                     cpu_done_o,
  output logic                     cpu_err_o,
  output logic                     cpu_busy_o,
  output logic                     stb_o,
  output logic                     cyc_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic                     ack_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     stall_i
);

  typedef enum logic [1:0] {IDLE, BUS, CHECK, STALL} state_e;

  state_e                   state_q, state_d;
  logic                     stb_q, stb_d;
  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     err_d;

  // Only the low address bits reach the TIA bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr_i[15:WB_ADDR_WIDTH];

`ifdef WB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q;

  // Timeout counter and error pulse register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cpu_err_o = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign cpu_err_o      = 1'b0;
`endif

  // State and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic.
  // NOTE: every target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef WB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // busy_q still covers the done/err cycle, so a request there is ignored.
        if (cpu_req_i && !busy_q) begin
          we_d    = cpu_we_i;
          adr_d   = cpu_addr_i[WB_ADDR_WIDTH-1:0];
          dat_d   = cpu_wdata_i;
          stb_d   = 1'b1;
          state_d = BUS;
`ifdef WB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUS: begin
        if (ack_i) begin
          stb_d   = 1'b0;
          if (!we_q) rdata_d = dat_i;
          state_d = CHECK;
        end
`ifdef WB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          stb_d   = 1'b0;
          err_d   = 1'b1;
          if (!we_q) rdata_d = '1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      CHECK: begin
        // The slave raises stall on the same edge as ack; look at it once settled.
        if (stall_i) begin
          state_d = STALL;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      STALL: begin
        if (!stall_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || done_d || err_d;
  end

  assign stb_o       = stb_q;
  assign cyc_o       = stb_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign cpu_rdata_o = rdata_q;
  assign cpu_done_o  = done_q;
  assign cpu_busy_o  = busy_q;

endmodule
